// File: rtl/pipe_ctrl.sv
// Pipeline hazard/stall controller: load-use interlock, branch flush, data-memory
// wait handling with timeout-to-error, plus stall and flush event counters.
module pipe_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        MemRead_E,
  input  logic [4:0]  WA_E,
  input  logic [4:0]  RA0_D,
  input  logic [4:0]  RA1_D,
  input  logic        UseRA0_D,
  input  logic        UseRA1_D,
  input  logic        Taken_E,
  input  logic        DReq_M,
  input  logic        DAck,
  output logic        Stall_F,
  output logic        Stall_D,
  output logic        Stall_E,
  output logic        Stall_M,
  output logic        Flush_D,
  output logic        Flush_E,
  output logic        Bubble_W,
  output logic        Err,
  output logic [31:0] StallCnt,
  output logic [15:0] FlushCnt
);

  localparam logic [1:0] RUN   = 2'd0;
  localparam logic [1:0] MWAIT = 2'd1;
  localparam logic [1:0] ERR   = 2'd2;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  logic [1:0]  state_q, state_d;
  logic [7:0]  wcnt_q, wcnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;
  logic        lu, ms, any_stall;

  always_comb begin
    lu = MemRead_E && (WA_E != 5'd0) &&
         ((UseRA0_D && (RA0_D == WA_E)) || (UseRA1_D && (RA1_D == WA_E)));
    ms = ((state_q == RUN) && DReq_M && !DAck) || ((state_q == MWAIT) && !DAck);

    Stall_F  = 1'b0;
    Stall_D  = 1'b0;
    Stall_E  = 1'b0;
    Stall_M  = 1'b0;
    Flush_D  = 1'b0;
    Flush_E  = 1'b0;
    Bubble_W = 1'b0;

    // Priority: reset, error, memory stall, taken branch, load-use.
    if (RST) begin
      Bubble_W = 1'b1;
    end else if (state_q == ERR || ms) begin
      Stall_F  = 1'b1;
      Stall_D  = 1'b1;
      Stall_E  = 1'b1;
      Stall_M  = 1'b1;
      Bubble_W = 1'b1;
    end else if (Taken_E) begin
      Flush_D = 1'b1;
      Flush_E = 1'b1;
    end else if (lu) begin
      Stall_F = 1'b1;
      Stall_D = 1'b1;
      Flush_E = 1'b1;
    end

    any_stall = Stall_F || Stall_D || Stall_E || Stall_M;
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      RUN: begin
        if (DReq_M && !DAck) begin
          state_d = MWAIT;
          wcnt_d  = 8'd1;
        end
      end
      MWAIT: begin
        // Completion on the timeout cycle still wins over the error.
        if (DAck) begin
          state_d = RUN;
          wcnt_d  = 8'd0;
        end else if (wcnt_q == TIMEOUT_C) begin
          state_d = ERR;
        end else begin
          wcnt_d = wcnt_q + 8'd1;
        end
      end
      ERR:     state_d = ERR;
      default: begin
        state_d = RUN;
        wcnt_d  = 8'd0;
      end
    endcase

    stall_cnt_d = stall_cnt_q;
    if (any_stall && (stall_cnt_q != 32'hFFFF_FFFF))
      stall_cnt_d = stall_cnt_q + 32'd1;

    flush_cnt_d = flush_cnt_q;
    if (Flush_D)
      flush_cnt_d = flush_cnt_q + 16'd1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= RUN;
      wcnt_q      <= 8'd0;
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign Err      = (state_q == ERR);
  assign StallCnt = stall_cnt_q;
  assign FlushCnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed scoreboard bench for pipe_ctrl (TIMEOUT=4): hazards, memory waits,
// timeout error, reset recovery.
module tb_pipe_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic        MemRead_E, UseRA0_D, UseRA1_D, Taken_E, DReq_M, DAck;
  logic [4:0]  WA_E, RA0_D, RA1_D;
  logic        Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E, Bubble_W, Err;
  logic [31:0] StallCnt;
  logic [15:0] FlushCnt;

  pipe_ctrl #(.TIMEOUT(4)) dut (
    .CLK(CLK), .RST(RST), .MemRead_E(MemRead_E), .WA_E(WA_E),
    .RA0_D(RA0_D), .RA1_D(RA1_D), .UseRA0_D(UseRA0_D), .UseRA1_D(UseRA1_D),
    .Taken_E(Taken_E), .DReq_M(DReq_M), .DAck(DAck),
    .Stall_F(Stall_F), .Stall_D(Stall_D), .Stall_E(Stall_E), .Stall_M(Stall_M),
    .Flush_D(Flush_D), .Flush_E(Flush_E), .Bubble_W(Bubble_W), .Err(Err),
    .StallCnt(StallCnt), .FlushCnt(FlushCnt)
  );

  always #5 CLK = ~CLK;

  // {Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E, Bubble_W, Err}
  logic [7:0] obs;
  assign obs = {Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E, Bubble_W, Err};

  localparam logic [7:0] O_NONE = 8'b0000_0000;
  localparam logic [7:0] O_LU   = 8'b1100_0100;
  localparam logic [7:0] O_TK   = 8'b0000_1100;
  localparam logic [7:0] O_MS   = 8'b1111_0010;
  localparam logic [7:0] O_ER   = 8'b1111_0011;
  localparam logic [7:0] O_RST  = 8'b0000_0010;

  typedef struct {
    string       tag;
    logic [7:0]  outs;
    logic [31:0] sc;
    logic [15:0] fc;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] exp_sc   = 32'd0;
  logic [15:0] exp_fc   = 16'd0;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_checks++;
    assert (o === e) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
  endtask

  task automatic step(input string tag, input logic mr, input logic [4:0] wa,
                      input logic [4:0] ra0, input logic [4:0] ra1,
                      input logic u0, input logic u1, input logic tk,
                      input logic dreq, input logic dack, input logic [7:0] eo);
    exp_t e;
    MemRead_E = mr;  WA_E = wa;   RA0_D = ra0; RA1_D = ra1;
    UseRA0_D  = u0;  UseRA1_D = u1; Taken_E = tk; DReq_M = dreq; DAck = dack;
    if (|eo[7:4]) exp_sc = exp_sc + 32'd1;
    if (eo[3])    exp_fc = exp_fc + 16'd1;
    e.tag = tag; e.outs = eo; e.sc = exp_sc; e.fc = exp_fc;
    sb.push_back(e);
    @(negedge CLK);
    e = sb.pop_front();
    chk({e.tag, "/outs"}, {24'd0, obs}, {24'd0, e.outs});
    @(posedge CLK); #1;
    chk({e.tag, "/stallcnt"}, StallCnt, e.sc);
    chk({e.tag, "/flushcnt"}, {16'd0, FlushCnt}, {16'd0, e.fc});
  endtask

  task automatic idle(input string tag, input logic [7:0] eo);
    step(tag, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, eo);
  endtask

  task automatic mem(input string tag, input logic dreq, input logic dack,
                     input logic tk, input logic [7:0] eo);
    step(tag, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, tk, dreq, dack, eo);
  endtask

  task automatic do_reset(input string tag);
    RST = 1'b1;
    MemRead_E = 0; WA_E = 0; RA0_D = 0; RA1_D = 0; UseRA0_D = 0; UseRA1_D = 0;
    Taken_E = 0; DReq_M = 0; DAck = 0;
    @(posedge CLK); #1;
    @(negedge CLK);
    chk({tag, "/outs_in_rst"}, {24'd0, obs}, {24'd0, O_RST});
    @(posedge CLK); #1;
    RST = 1'b0;
    exp_sc = 32'd0;
    exp_fc = 16'd0;
    chk({tag, "/stallcnt"}, StallCnt, 32'd0);
    chk({tag, "/flushcnt"}, {16'd0, FlushCnt}, 32'd0);
    chk({tag, "/err"}, {31'd0, Err}, 32'd0);
  endtask

  initial begin
    do_reset("reset0");
    idle("idle0", O_NONE);

    // Load-use interlock and its qualifiers
    step("lu_ra1",     1, 5'd5, 5'd0, 5'd5, 0, 1, 0, 0, 0, O_LU);
    step("lu_ra0",     1, 5'd9, 5'd9, 5'd3, 1, 0, 0, 0, 0, O_LU);
    step("lu_unused",  1, 5'd5, 5'd0, 5'd5, 0, 0, 0, 0, 0, O_NONE);
    step("lu_r0",      1, 5'd0, 5'd0, 5'd1, 1, 0, 0, 0, 0, O_NONE);
    step("lu_noload",  0, 5'd5, 5'd5, 5'd5, 1, 1, 0, 0, 0, O_NONE);
    step("lu_taken",   1, 5'd5, 5'd0, 5'd5, 0, 1, 1, 0, 0, O_TK);
    chk("after_lu/stallcnt", StallCnt, 32'd2);

    // Three-cycle data-memory wait, then zero-wait access and stray DAck
    mem("mw3_run",   1, 0, 0, O_MS);
    mem("mw3_w1",    1, 0, 0, O_MS);
    mem("mw3_w2",    1, 0, 0, O_MS);
    mem("mw3_ack",   1, 1, 0, O_NONE);
    chk("mw3/stallcnt", StallCnt, 32'd5);
    mem("zero_wait", 1, 1, 0, O_NONE);
    mem("stray_ack", 0, 1, 0, O_NONE);
    idle("idle1", O_NONE);

    // Taken branch and load-use held during a wait, flush lands on the ack
    mem("mwt_run",   1, 0, 0, O_MS);
    step("mwt_w1_lu", 1, 5'd5, 5'd0, 5'd5, 0, 1, 1, 1, 0, O_MS);
    mem("mwt_w2",    1, 0, 1, O_MS);
    mem("mwt_ack",   1, 1, 1, O_TK);
    chk("mwt/flushcnt", {16'd0, FlushCnt}, 32'd2);
    idle("idle2", O_NONE);

    // Ack on the cycle the wait counter reaches TIMEOUT completes normally
    mem("edge_run",  1, 0, 0, O_MS);
    mem("edge_w1",   1, 0, 0, O_MS);
    mem("edge_w2",   1, 0, 0, O_MS);
    mem("edge_w3",   1, 0, 0, O_MS);
    mem("edge_ack",  1, 1, 0, O_NONE);
    idle("idle3", O_NONE);

    // Timeout: five stalled cycles, then sticky error ignoring ack and branch
    mem("to_run",    1, 0, 0, O_MS);
    mem("to_w1",     1, 0, 0, O_MS);
    mem("to_w2",     1, 0, 0, O_MS);
    mem("to_w3",     1, 0, 0, O_MS);
    mem("to_w4",     1, 0, 0, O_MS);
    mem("err0",      1, 1, 1, O_ER);
    idle("err1", O_ER);
    chk("err/stallcnt", StallCnt, 32'd19);
    do_reset("reset_err");
    idle("idle4", O_NONE);

    // Reset in the middle of a wait abandons the access
    mem("ab_run",    1, 0, 0, O_MS);
    mem("ab_w1",     1, 0, 0, O_MS);
    do_reset("reset_mw");
    idle("ab_after", O_NONE);
    step("lu_final", 1, 5'd7, 5'd7, 5'd0, 1, 0, 0, 0, 0, O_LU);

    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
